// File: rtl/shift_reg2d_pkg.sv
// Shared mode encodings and popcount helper for the 2D shift register.
// Optional rotate mode is enabled by defining SHIFT_REG2D_ROTATE_EN.
package shift_reg2d_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_ROT  = 2'b11;

  // Widest valid vector the popcount helper accepts; callers zero-extend.
  localparam int POP_MAX_W = 256;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] vec);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n += {31'd0, vec[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/shift_reg2d_tap_mux.sv
// Registered DEPTH:1 tap selector over the flat stage bus plus valid bits.
// Selects at or beyond DEPTH read back as zero with the valid bit cleared.
module shift_reg2d_tap_mux #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [WIDTH*DEPTH-1:0] data,
  input  logic [DEPTH-1:0]       valid,
  input  logic [SEL_W-1:0]       tap_sel,
  output logic [WIDTH-1:0]       tap_out,
  output logic                   tap_valid
);

  logic [WIDTH-1:0] word_d;
  logic             valid_d;

  // Only in-range indices can match, so out-of-range selects fall to zero.
  always_comb begin
    word_d  = '0;
    valid_d = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == SEL_W'(i)) begin
        word_d  = data[i*WIDTH +: WIDTH];
        valid_d = valid[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tap_out   <= '0;
      tap_valid <= 1'b0;
    end else begin
      tap_out   <= word_d;
      tap_valid <= valid_d;
    end
  end

endmodule

// File: rtl/shift_reg2d_param.sv
// Parametrised 2D shift register: bidirectional shift, clear, tap and spill ports.
// Define SHIFT_REG2D_ROTATE_EN to make mode 11 rotate up; otherwise it holds.
module shift_reg2d_param
  import shift_reg2d_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH+1),
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [1:0]             mode,
  input  logic                   clr,
  input  logic [WIDTH-1:0]       in,
  input  logic                   in_valid,
  input  logic [SEL_W-1:0]       tap_sel,
  output logic [WIDTH*DEPTH-1:0] out_all,
  output logic [DEPTH-1:0]       valid_all,
  output logic [WIDTH-1:0]       tap_out,
  output logic                   tap_valid,
  output logic [WIDTH-1:0]       spill,
  output logic                   spill_valid,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty
);

  localparam int TOTAL_W = WIDTH * DEPTH;

  logic [TOTAL_W-1:0] data_q, data_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [WIDTH-1:0]   spill_q, spill_d;
  logic               spill_valid_q, spill_valid_d;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   top_word, bottom_word;

  assign top_word    = data_q[TOTAL_W-1 -: WIDTH];
  assign bottom_word = data_q[WIDTH-1:0];

  // The spill register only loads when the word leaving is valid, so it
  // keeps the last real word across holds and invalid pushes.
  always_comb begin
    data_d        = data_q;
    valid_d       = valid_q;
    spill_d       = spill_q;
    spill_valid_d = 1'b0;
    if (clr) begin
      data_d  = '0;
      valid_d = '0;
    end else begin
      case (mode)
        MODE_UP: begin
          data_d  = {data_q[TOTAL_W-WIDTH-1:0], in};
          valid_d = {valid_q[DEPTH-2:0], in_valid};
          if (valid_q[DEPTH-1]) begin
            spill_d       = top_word;
            spill_valid_d = 1'b1;
          end
        end
        MODE_DOWN: begin
          data_d  = {in, data_q[TOTAL_W-1:WIDTH]};
          valid_d = {in_valid, valid_q[DEPTH-1:1]};
          if (valid_q[0]) begin
            spill_d       = bottom_word;
            spill_valid_d = 1'b1;
          end
        end
`ifdef SHIFT_REG2D_ROTATE_EN
        MODE_ROT: begin
          data_d  = {data_q[TOTAL_W-WIDTH-1:0], top_word};
          valid_d = {valid_q[DEPTH-2:0], valid_q[DEPTH-1]};
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q        <= '0;
      valid_q       <= '0;
      spill_q       <= '0;
      spill_valid_q <= 1'b0;
      count_q       <= '0;
    end else begin
      data_q        <= data_d;
      valid_q       <= valid_d;
      spill_q       <= spill_d;
      spill_valid_q <= spill_valid_d;
      count_q       <= CNT_W'(popcount(POP_MAX_W'(valid_d)));
    end
  end

  shift_reg2d_tap_mux #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) u_tap_mux (
    .clk       (clk),
    .rstn      (rstn),
    .data      (data_q),
    .valid     (valid_q),
    .tap_sel   (tap_sel),
    .tap_out   (tap_out),
    .tap_valid (tap_valid)
  );

  assign out_all     = data_q;
  assign valid_all   = valid_q;
  assign spill       = spill_q;
  assign spill_valid = spill_valid_q;
  assign count       = count_q;
  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);

endmodule

// File: tb/tb_shift_reg2d_param.sv
// Scoreboard bench for shift_reg2d_param: DEPTH=16 main instance plus a
// DEPTH=12 instance for the out-of-range tap select.
module tb_shift_reg2d_param;
  import shift_reg2d_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] mode;
  logic       clr;
  logic [3:0] in_d;
  logic       in_valid;
  logic [3:0] tap_sel, tap_sel12;

  logic [63:0] out_all;
  logic [15:0] valid_all;
  logic [3:0]  tap_out, spill;
  logic        tap_valid, spill_valid, full, empty;
  logic [4:0]  count;

  logic [47:0] out_all12;
  logic [11:0] valid_all12;
  logic [3:0]  tap_out12, spill12, count12;
  logic        tap_valid12, spill_valid12, full12, empty12;

  shift_reg2d_param #(.WIDTH(4), .DEPTH(16)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .clr(clr), .in(in_d), .in_valid(in_valid),
    .tap_sel(tap_sel), .out_all(out_all), .valid_all(valid_all), .tap_out(tap_out),
    .tap_valid(tap_valid), .spill(spill), .spill_valid(spill_valid), .count(count),
    .full(full), .empty(empty)
  );

  shift_reg2d_param #(.WIDTH(4), .DEPTH(12)) dut12 (
    .clk(clk), .rstn(rstn), .mode(mode), .clr(clr), .in(in_d), .in_valid(in_valid),
    .tap_sel(tap_sel12), .out_all(out_all12), .valid_all(valid_all12), .tap_out(tap_out12),
    .tap_valid(tap_valid12), .spill(spill12), .spill_valid(spill_valid12), .count(count12),
    .full(full12), .empty(empty12)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  int n_pass = 0;
  int n_total = 0;
  int tgt = 0;

  typedef struct {
    int          cyc;
    string       name;
    bit          c_all;
    logic [63:0] all;
    logic [15:0] vall;
    bit          c_cnt;
    logic [4:0]  cnt;
    bit          c_sp;
    logic [3:0]  sp;
    logic        spv;
    bit          c_tap;
    logic [3:0]  tap;
    logic        tapv;
    bit          c_tap12;
    logic [3:0]  tap12;
    logic        tapv12;
  } exp_t;

  exp_t q[$];
  exp_t e, m_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
  endtask

  function automatic exp_t blank(input string n);
    exp_t r;
    r.cyc = tgt; r.name = n;
    r.c_all = 0; r.all = '0; r.vall = '0;
    r.c_cnt = 0; r.cnt = '0;
    r.c_sp = 0; r.sp = '0; r.spv = 1'b0;
    r.c_tap = 0; r.tap = '0; r.tapv = 1'b0;
    r.c_tap12 = 0; r.tap12 = '0; r.tapv12 = 1'b0;
    return r;
  endfunction

  // Stage contents after 16 fill pushes of 1..16 and one push of 0xA.
  function automatic logic [3:0] s17(input int i);
    return (i == 0) ? 4'hA : 4'(17 - i);
  endfunction

  // Stage contents after 16 valid pushes of 1..16 and 3 invalid zero pushes.
  function automatic logic [3:0] vrot(input int i);
    return (i < 3) ? 4'h0 : 4'(19 - i);
  endfunction

  task automatic drive(input logic [1:0] m, input logic c, input logic [3:0] d,
                       input logic dv, input logic [3:0] ts, input logic [3:0] ts12);
    @(posedge clk);
    #1;
    mode = m; clr = c; in_d = d; in_valid = dv; tap_sel = ts; tap_sel12 = ts12;
    tgt = edge_cnt + 1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
      m_e = q.pop_front();
      if (m_e.c_all) begin
        chk({m_e.name, "_out_all"}, out_all, m_e.all);
        chk({m_e.name, "_valid_all"}, 64'(valid_all), 64'(m_e.vall));
      end
      if (m_e.c_cnt) begin
        chk({m_e.name, "_count"}, 64'(count), 64'(m_e.cnt));
        chk({m_e.name, "_full"}, 64'(full), 64'(m_e.cnt == 5'd16));
        chk({m_e.name, "_empty"}, 64'(empty), 64'(m_e.cnt == 5'd0));
      end
      if (m_e.c_sp) begin
        chk({m_e.name, "_spill_valid"}, 64'(spill_valid), 64'(m_e.spv));
        chk({m_e.name, "_spill"}, 64'(spill), 64'(m_e.sp));
      end
      if (m_e.c_tap) begin
        chk({m_e.name, "_tap_out"}, 64'(tap_out), 64'(m_e.tap));
        chk({m_e.name, "_tap_valid"}, 64'(tap_valid), 64'(m_e.tapv));
      end
      if (m_e.c_tap12) begin
        chk({m_e.name, "_tap12_out"}, 64'(tap_out12), 64'(m_e.tap12));
        chk({m_e.name, "_tap12_valid"}, 64'(tap_valid12), 64'(m_e.tapv12));
      end
    end
  end

  initial begin
    int j;
    mode = MODE_HOLD; clr = 0; in_d = 0; in_valid = 0; tap_sel = 0; tap_sel12 = 0;
    #3;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_out_all", out_all, 64'd0);
    chk("rst_valid_all", 64'(valid_all), 64'd0);
    chk("rst_spill", 64'({spill_valid, spill}), 64'd0);
    chk("rst_tap", 64'({tap_valid, tap_out}), 64'd0);
    #9 rstn = 1'b1;

    for (int k = 1; k <= 16; k++) begin
      drive(MODE_UP, 0, 4'(k), 1, 4'd0, 4'd0);
      e = blank($sformatf("fill%0d", k));
      e.c_cnt = 1; e.cnt = 5'(k);
      e.c_sp = 1; e.sp = 4'h0; e.spv = 1'b0;
      if (k == 16) begin
        e.c_all = 1; e.vall = '1;
        for (int i = 0; i < 16; i++) e.all[i*4 +: 4] = 4'(16 - i);
      end
      q.push_back(e);
    end

    drive(MODE_UP, 0, 4'hA, 1, 4'd0, 4'd0);
    e = blank("push17");
    e.c_cnt = 1; e.cnt = 5'd16;
    e.c_sp = 1; e.sp = 4'h1; e.spv = 1'b1;
    e.c_all = 1; e.vall = '1;
    for (int i = 0; i < 16; i++) e.all[i*4 +: 4] = s17(i);
    q.push_back(e);

    for (int s = 0; s < 16; s++) begin
      drive(MODE_HOLD, 0, 4'h0, 0, 4'(s), (s == 5) ? 4'd11 : 4'd13);
      e = blank($sformatf("tap%0d", s));
      e.c_tap = 1; e.tap = s17(s); e.tapv = 1'b1;
      e.c_tap12 = 1;
      if (s == 5) begin e.tap12 = 4'h6; e.tapv12 = 1'b1; end
      if (s == 0) begin e.c_sp = 1; e.sp = 4'h1; e.spv = 1'b0; end
      q.push_back(e);
    end

    for (int k = 1; k <= 4; k++) begin
      drive(MODE_DOWN, 0, 4'hF, 0, 4'd0, 4'd0);
      e = blank($sformatf("down%0d", k));
      e.c_cnt = 1; e.cnt = 5'(16 - k);
      e.c_sp = 1; e.sp = s17(k - 1); e.spv = 1'b1;
      q.push_back(e);
    end
    for (int k = 1; k <= 16; k++) begin
      drive(MODE_DOWN, 0, 4'hF, 0, 4'd0, 4'd0);
      e = blank($sformatf("drain%0d", k));
      e.c_cnt = 1; e.c_sp = 1;
      if (k <= 12) begin
        e.cnt = 5'(12 - k); e.sp = 4'(14 - k); e.spv = 1'b1;
      end else begin
        e.cnt = 5'd0; e.sp = 4'h2; e.spv = 1'b0;
      end
      if (k == 16) begin e.c_all = 1; e.all = '1; e.vall = '0; end
      q.push_back(e);
    end

    for (int k = 1; k <= 9; k++) begin
      drive(MODE_UP, 0, 4'(k), 1, 4'd0, 4'd0);
      e = blank($sformatf("load%0d", k));
      e.c_cnt = 1; e.cnt = 5'(k);
      q.push_back(e);
    end
    drive(MODE_UP, 1, 4'h7, 1, 4'd0, 4'd0);
    e = blank("clr_up");
    e.c_cnt = 1; e.cnt = 5'd0;
    e.c_all = 1; e.all = '0; e.vall = '0;
    e.c_sp = 1; e.sp = 4'h2; e.spv = 1'b0;
    q.push_back(e);
    drive(MODE_HOLD, 0, 4'h0, 0, 4'd0, 4'd0);
    e = blank("after_clr");
    e.c_cnt = 1; e.cnt = 5'd0;
    e.c_all = 1; e.all = '0; e.vall = '0;
    q.push_back(e);

    for (int k = 1; k <= 16; k++) drive(MODE_UP, 0, 4'(k), 1, 4'd0, 4'd0);
    for (int k = 1; k <= 3; k++) drive(MODE_UP, 0, 4'h0, 0, 4'd0, 4'd0);
    e = blank("rot_load");
    e.c_cnt = 1; e.cnt = 5'd13;
    e.c_sp = 1; e.sp = 4'h3; e.spv = 1'b1;
    e.c_all = 1;
    for (int i = 0; i < 16; i++) begin
      e.all[i*4 +: 4] = vrot(i); e.vall[i] = (i >= 3);
    end
    q.push_back(e);

    for (int r = 1; r <= 16; r++) begin
      drive(MODE_ROT, 0, 4'h9, 1, 4'd0, 4'd0);
      e = blank($sformatf("rot%0d", r));
      e.c_cnt = 1; e.cnt = 5'd13;
      e.c_sp = 1; e.sp = 4'h3; e.spv = 1'b0;
      if (r == 1 || r == 16) begin
        e.c_all = 1;
        for (int i = 0; i < 16; i++) begin
`ifdef SHIFT_REG2D_ROTATE_EN
          j = (i - (r % 16) + 16) % 16;
`else
          j = i;
`endif
          e.all[i*4 +: 4] = vrot(j); e.vall[i] = (j >= 3);
        end
      end
      q.push_back(e);
    end

    drive(MODE_UP, 0, 4'h5, 1, 4'd0, 4'd0);
    e = blank("pre_rst");
    e.c_cnt = 1; e.cnt = 5'd13;
    e.c_sp = 1; e.sp = 4'h4; e.spv = 1'b1;
    q.push_back(e);
    drive(MODE_UP, 0, 4'h6, 1, 4'd0, 4'd0);
    #6 rstn = 1'b0;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    chk("mid_rst_out_all", out_all, 64'd0);
    chk("mid_rst_valid_all", 64'(valid_all), 64'd0);
    chk("mid_rst_spill", 64'({spill_valid, spill}), 64'd0);
    chk("mid_rst_tap", 64'({tap_valid, tap_out}), 64'd0);
    #1 rstn = 1'b1;
    e = blank("resume1");
    e.c_cnt = 1; e.cnt = 5'd1;
    e.c_all = 1; e.all = 64'h6; e.vall = 16'h0001;
    q.push_back(e);
    drive(MODE_UP, 0, 4'h7, 1, 4'd0, 4'd0);
    e = blank("resume2");
    e.c_cnt = 1; e.cnt = 5'd2;
    e.c_all = 1; e.all = 64'h67; e.vall = 16'h0003;
    e.c_sp = 1; e.sp = 4'h0; e.spv = 1'b0;
    q.push_back(e);
    drive(MODE_HOLD, 0, 4'h0, 0, 4'd0, 4'd0);

    repeat (4) @(posedge clk);
    if (q.size() != 0) chk("scoreboard_drain", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
